// File: rtl/flag_hazard_controller_pkg.sv
// Shared constants for the flag hazard controller.
// ARM condition codes, flag bit positions and FSM states.
package flag_hazard_controller_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Flags are packed {z,c,n,v}.
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_STALL
  } state_e;

endpackage

// File: rtl/flag_hazard_controller_cond_eval.sv
// Combinational ARM condition evaluator.
// Ports: cond (condition field), flags {z,c,n,v}, pass.
module cond_eval
  import flag_hazard_controller_pkg::*;
#(
  parameter int COND_LEN = 4
) (
  input  logic [COND_LEN-1:0] cond,
  input  logic [3:0]          flags,
  output logic                pass
);

  logic z, c, n, v;

  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_hazard_controller.sv
// Issues conditional instructions from decode to execute, owns the
// status register, stalls on in-flight flag writers, bypasses wb flags.
// Ports: clk, rst_n; id_* decode handshake; wb_flag_valid/wb_flags;
// flush; ex_* issue outputs; status_register, pending_cnt,
// stall_cycles, flag_err.
module flag_hazard_controller
  import flag_hazard_controller_pkg::*;
#(
  parameter int MAX_PENDING = 3,
  parameter int COND_LEN    = 4,
  localparam int PW = $clog2(MAX_PENDING + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [COND_LEN-1:0] id_cond,
  input  logic                id_s,
  input  logic                wb_flag_valid,
  input  logic [3:0]          wb_flags,
  input  logic                flush,
  output logic                ex_valid,
  output logic                ex_execute,
  output logic                ex_s,
  output logic [3:0]          status_register,
  output logic [PW-1:0]       pending_cnt,
  output logic [15:0]         stall_cycles,
  output logic                flag_err
);

  logic [3:0]    eff_flags;
  logic [PW-1:0] eff_pending;
  logic [PW-1:0] pend_nxt;
  logic          wb_dec;
  logic          hazard;
  logic          full;
  logic          accept;
  logic          pass;
  logic          stall;
  logic          ex_s_nxt;
  state_e        state;
  state_e        state_nxt;

  // A writeback this cycle retires one writer and its flags are
  // usable right away, so issue never waits an extra cycle.
  assign wb_dec      = wb_flag_valid & (pending_cnt != '0);
  assign eff_flags   = wb_flag_valid ? wb_flags : status_register;
  assign eff_pending = pending_cnt - PW'(wb_dec);

  assign hazard   = (id_cond != COND_LEN'(COND_AL))
                  & (eff_pending != '0);
  assign full     = id_s & (eff_pending == PW'(MAX_PENDING));
  assign id_ready = ~flush & ~hazard & ~full;
  assign accept   = id_valid & id_ready;
  assign ex_s_nxt = accept & id_s & pass;
  assign stall    = id_valid & hazard & ~flush;

  cond_eval #(
    .COND_LEN (COND_LEN)
  ) u_cond_eval (
    .cond  (id_cond),
    .flags (eff_flags),
    .pass  (pass)
  );

  always_comb begin
    pend_nxt  = eff_pending + PW'(ex_s_nxt);
    state_nxt = ST_IDLE;
    if (flush) begin
      pend_nxt  = '0;
      state_nxt = ST_IDLE;
    end else if (stall) begin
      state_nxt = ST_STALL;
    end else if (pend_nxt != '0) begin
      state_nxt = ST_PENDING;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      pending_cnt     <= '0;
      status_register <= '0;
      ex_valid        <= 1'b0;
      ex_execute      <= 1'b0;
      ex_s            <= 1'b0;
      stall_cycles    <= '0;
      flag_err        <= 1'b0;
    end else begin
      state       <= state_nxt;
      pending_cnt <= pend_nxt;
      ex_valid    <= accept;
      ex_execute  <= accept & pass;
      ex_s        <= ex_s_nxt;
      if (wb_flag_valid)
        status_register <= wb_flags;
      if (wb_flag_valid && pending_cnt == '0 && !flush)
        flag_err <= 1'b1;
      if (state == ST_STALL && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_flag_hazard_controller.sv
// Directed self-checking bench for flag_hazard_controller.
// Inputs change 1ns after rising edges; outputs are checked there too.
module tb_flag_hazard_controller;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [3:0]  id_cond;
  logic        id_s;
  logic        wb_flag_valid;
  logic [3:0]  wb_flags;
  logic        flush;
  logic        ex_valid;
  logic        ex_execute;
  logic        ex_s;
  logic [3:0]  status_register;
  logic [1:0]  pending_cnt;
  logic [15:0] stall_cycles;
  logic        flag_err;

  int n_checks;
  int n_fail;

  localparam logic [3:0] EQ = 4'b0000;
  localparam logic [3:0] CS = 4'b0010;
  localparam logic [3:0] LS = 4'b1001;
  localparam logic [3:0] LT = 4'b1011;
  localparam logic [3:0] GT = 4'b1100;
  localparam logic [3:0] AL = 4'b1110;
  localparam logic [3:0] NV = 4'b1111;

  flag_hazard_controller #(
    .MAX_PENDING (3),
    .COND_LEN    (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_cond         (id_cond),
    .id_s            (id_s),
    .wb_flag_valid   (wb_flag_valid),
    .wb_flags        (wb_flags),
    .flush           (flush),
    .ex_valid        (ex_valid),
    .ex_execute      (ex_execute),
    .ex_s            (ex_s),
    .status_register (status_register),
    .pending_cnt     (pending_cnt),
    .stall_cycles    (stall_cycles),
    .flag_err        (flag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c,
                       input logic s);
    id_valid = v;
    id_cond  = c;
    id_s     = s;
  endtask

  task automatic wb(input logic v, input logic [3:0] f);
    wb_flag_valid = v;
    wb_flags      = f;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    drive(1'b0, AL, 1'b0);
    wb(1'b0, 4'b0000);
    tick();
    tick();

    // Reset state
    chk("rst_status", 16'(status_register), 16'h0);
    chk("rst_pending", 16'(pending_cnt), 16'h0);
    chk("rst_ex_valid", 16'(ex_valid), 16'h0);
    chk("rst_ex_execute", 16'(ex_execute), 16'h0);
    chk("rst_ex_s", 16'(ex_s), 16'h0);
    chk("rst_stall", stall_cycles, 16'h0);
    chk("rst_flag_err", 16'(flag_err), 16'h0);
    rst_n = 1'b1;

    // AL non-S stream
    drive(1'b1, AL, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("al_ready", 16'(id_ready), 16'h1);
      tick();
      chk("al_ex_valid", 16'(ex_valid), 16'h1);
      chk("al_ex_execute", 16'(ex_execute), 16'h1);
      chk("al_pending", 16'(pending_cnt), 16'h0);
    end

    // S then EQ; writeback 3 cycles after the S issues
    drive(1'b1, AL, 1'b1);
    tick();
    chk("s_ex_s", 16'(ex_s), 16'h1);
    chk("s_pending", 16'(pending_cnt), 16'h1);
    drive(1'b1, EQ, 1'b0);
    #1;
    chk("eq_stall_ready1", 16'(id_ready), 16'h0);
    tick();
    chk("eq_stall_exv1", 16'(ex_valid), 16'h0);
    #1;
    chk("eq_stall_ready2", 16'(id_ready), 16'h0);
    tick();
    chk("eq_stall_exv2", 16'(ex_valid), 16'h0);
    wb(1'b1, 4'b1000);
    #1;
    chk("eq_bypass_ready", 16'(id_ready), 16'h1);
    tick();
    chk("eq_ex_valid", 16'(ex_valid), 16'h1);
    chk("eq_ex_execute", 16'(ex_execute), 16'h1);
    chk("eq_pending", 16'(pending_cnt), 16'h0);
    chk("eq_status", 16'(status_register), 16'h8);
    chk("eq_stall_cycles", stall_cycles, 16'd2);
    chk("eq_flag_err", 16'(flag_err), 16'h0);
    wb(1'b0, 4'b0000);

    // Fill to MAX_PENDING, 4th S held until a writeback
    drive(1'b1, AL, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("fill_pending", 16'(pending_cnt), 16'(i));
    end
    #1;
    chk("full_ready", 16'(id_ready), 16'h0);
    tick();
    chk("full_ex_valid", 16'(ex_valid), 16'h0);
    chk("full_pending", 16'(pending_cnt), 16'd3);
    wb(1'b1, 4'b0000);
    #1;
    chk("full_wb_ready", 16'(id_ready), 16'h1);
    tick();
    chk("full_ex_s", 16'(ex_s), 16'h1);
    chk("full_inc_dec", 16'(pending_cnt), 16'd3);
    drive(1'b0, AL, 1'b0);
    tick();
    tick();
    wb(1'b1, 4'b0011);
    tick();
    chk("drain_pending", 16'(pending_cnt), 16'h0);
    chk("drain_status", 16'(status_register), 16'h3);
    chk("drain_flag_err", 16'(flag_err), 16'h0);
    wb(1'b0, 4'b0000);

    // Condition evaluation with n=1, v=1, z=0, c=0
    drive(1'b1, GT, 1'b0);
    tick();
    chk("gt_execute", 16'(ex_execute), 16'h1);
    drive(1'b1, LT, 1'b0);
    tick();
    chk("lt_execute", 16'(ex_execute), 16'h0);
    drive(1'b1, NV, 1'b0);
    tick();
    chk("nv_ex_valid", 16'(ex_valid), 16'h1);
    chk("nv_execute", 16'(ex_execute), 16'h0);
    drive(1'b1, EQ, 1'b1);
    tick();
    chk("eqs_execute", 16'(ex_execute), 16'h0);
    chk("eqs_ex_s", 16'(ex_s), 16'h0);
    chk("eqs_pending", 16'(pending_cnt), 16'h0);

    // Flush with simultaneous writeback
    drive(1'b1, AL, 1'b1);
    tick();
    tick();
    chk("pre_flush_pending", 16'(pending_cnt), 16'd2);
    drive(1'b1, AL, 1'b0);
    flush = 1'b1;
    wb(1'b1, 4'b0100);
    #1;
    chk("flush_ready", 16'(id_ready), 16'h0);
    tick();
    chk("flush_pending", 16'(pending_cnt), 16'h0);
    chk("flush_status", 16'(status_register), 16'h4);
    chk("flush_flag_err", 16'(flag_err), 16'h0);
    chk("flush_ex_valid", 16'(ex_valid), 16'h0);
    flush = 1'b0;
    wb(1'b0, 4'b0000);
    drive(1'b1, CS, 1'b0);
    #1;
    chk("post_flush_ready", 16'(id_ready), 16'h1);
    tick();
    chk("cs_ex_valid", 16'(ex_valid), 16'h1);
    chk("cs_execute", 16'(ex_execute), 16'h1);
    drive(1'b1, LS, 1'b0);
    tick();
    chk("ls_execute", 16'(ex_execute), 16'h0);

    // Spurious writeback sets sticky flag_err
    drive(1'b0, AL, 1'b0);
    wb(1'b1, 4'b1111);
    tick();
    chk("err_set", 16'(flag_err), 16'h1);
    chk("err_status", 16'(status_register), 16'hF);
    chk("err_pending", 16'(pending_cnt), 16'h0);
    wb(1'b0, 4'b0000);
    tick();
    tick();
    chk("err_sticky", 16'(flag_err), 16'h1);

    // Asynchronous reset in the middle of a stall
    drive(1'b1, AL, 1'b1);
    tick();
    drive(1'b1, EQ, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pending", 16'(pending_cnt), 16'h0);
    chk("arst_stall", stall_cycles, 16'h0);
    chk("arst_flag_err", 16'(flag_err), 16'h0);
    chk("arst_status", 16'(status_register), 16'h0);
    rst_n = 1'b1;
    #1;
    chk("arst_ready", 16'(id_ready), 16'h1);
    tick();
    chk("arst_ex_valid", 16'(ex_valid), 16'h1);
    chk("arst_ex_execute", 16'(ex_execute), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_hazard_controller.md
# flag_hazard_controller

Sequences conditionally executed instructions from decode into execute of the ARM core. Owns the architectural status register. Tracks in-flight flag-setting instructions and stalls decode when a conditional instruction needs flags that are not yet written back. Evaluates each issued condition against the current flags, or against flags bypassed from writeback, and tells execute whether to commit or squash the instruction.

## Interface
Parameters:
- MAX_PENDING, 3: maximum number of flag-setting instructions in flight between issue and writeback. Also sets the counter width.
- COND_LEN, 4: width of the condition field.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- id_valid, input, 1: decode presents an instruction.
- id_ready, output, 1: combinational; the instruction is accepted when id_valid & id_ready.
- id_cond, input, COND_LEN: condition field, ARM encoding.
- id_s, input, 1: the instruction writes flags (S bit).
- wb_flag_valid, input, 1: writeback delivers new flags this cycle.
- wb_flags, input, 4: new flags, ordered {z,c,n,v}.
- flush, input, 1: pipeline flush (branch taken); the pipeline kills all in-flight instructions.
- ex_valid, output, 1: registered; an instruction was issued last cycle.
- ex_execute, output, 1: registered; the condition passed. 0 means squash.
- ex_s, output, 1: registered; the issued instruction writes flags. Equal to id_s & condition-passed.
- status_register, output, 4: architectural flags {z,c,n,v}.
- pending_cnt, output, clog2(MAX_PENDING+1): number of flag writers in flight.
- stall_cycles, output, 16: saturating count of cycles stalled on a flag hazard.
- flag_err, output, 1: sticky. Set by wb_flag_valid while pending_cnt==0.

## Operation
- Condition encodings: EQ 0000, NE 0001, CS 0010, CC 0011, MI 0100, PL 0101, VS 0110, VC 0111, HI 1000, LS 1001, GE 1010, LT 1011, GT 1100, LE 1101, AL 1110, NV 1111.
- NV never executes.
- GE = (n==v); LT = (n!=v); GT = ~z & (n==v); LE = z | (n!=v); HI = c & ~z; LS = ~c | z.
- Effective flags (eff_flags) = wb_flag_valid ? wb_flags : status_register. This is the same-cycle bypass.
- eff_pending = pending_cnt - (wb_flag_valid & pending_cnt != 0).
- Hazard: id_cond != AL and eff_pending != 0.
- Full: id_s and eff_pending == MAX_PENDING.
- id_ready = ~flush & ~hazard & ~full.
- On accept:
  - ex_valid=1.
  - ex_execute = cond_eval(id_cond, eff_flags).
  - ex_s = id_s & ex_execute.
  - pending_cnt increments if ex_s.
- No accept: ex_valid=0, ex_execute=0, ex_s=0.
- Writeback with pending_cnt>0: status_register <= wb_flags, and pending_cnt decrements.
- Increment and decrement in the same cycle leave pending_cnt unchanged.
- Writeback with pending_cnt==0: status_register still updates, pending_cnt stays 0, and flag_err is set.
- Flush:
  - pending_cnt <= 0; ex_valid <= 0.
  - A wb_flag_valid in the same cycle still updates status_register.
  - flag_err is not set that cycle.
- State machine:
  - IDLE: pending_cnt==0.
  - PENDING: pending_cnt>0, no stall.
  - STALL: id_valid & hazard.
  - Transitions are evaluated each cycle from the next-state pending_cnt and the stall condition.
  - Flush forces IDLE.
- stall_cycles increments in every cycle spent in STALL and saturates at 0xFFFF.

## Timing
- Reset values: status_register=0, pending_cnt=0, ex_valid=0, ex_execute=0, ex_s=0, stall_cycles=0, flag_err=0, state IDLE.
- Issue latency is 1 cycle: accept at edge t produces ex_* valid for cycle t+1.
- Writeback at cycle t is visible on status_register at t+1. It is usable by an issue in cycle t through the bypass.
- A conditional instruction that follows a flag-setter issues the same cycle the last pending writeback arrives. It does not wait an extra cycle.
- Reset mid-stall: all state clears immediately (asynchronous). id_ready is governed by the IDLE rules once reset is released.

## Structure
- Condition encodings, flag bit positions, and AL/NV constants belong in the shared constants file.
- One combinational sub-module, cond_eval (inputs cond, flags; output pass), instantiated once on eff_flags.
- The counter, state register, and output registers live in the top module.

## Test plan
- Reset, then an AL non-S instruction every cycle → id_ready=1 continuously; ex_valid=1 from cycle 2; pending_cnt=0.
- Issue an S instruction (AL), then EQ next cycle; writeback of flags 4'b1000 three cycles later → EQ stalls; stall_cycles=2; EQ issues in the writeback cycle with ex_execute=1.
- Issue MAX_PENDING=3 S instructions with no writeback, then a 4th S → 4th is held (id_ready=0) until one writeback arrives.
- Status 4'b0011 (n=1, v=1, z=0), issue GT, then LT → ex_execute 1 then 0. Issue NV → ex_valid=1, ex_execute=0.
- With pending_cnt=2, assert flush and wb_flag_valid together with flags 4'b0100 → pending_cnt=0, status_register=4'b0100, flag_err=0. A following conditional issues immediately.
- Writeback with pending_cnt=0 → flag_err=1 and stays set until reset.
